shared_fu_arbiter: RTL and testbench
====================================

Name: shared_fu_arbiter

Overview:
- Time-multiplexes one arithmetic functional unit between NUM_CLIENTS dataflow channels using the req/ack pull handshake used by async_operator.
- Per client, the block pulls an operand pair, computes a result over LATENCY cycles, and pushes the result back with a one-cycle ack.
- Round-robin fairness. One transaction in flight at a time.
- Sits in arf-style graphs wherever several add/mul nodes are folded onto a single unit.

Parameters:
- NUM_CLIENTS, 4: number of requesters (2..16).
- DATA_WIDTH, 32: operand and result width.
- OP, "add": function; one of "add", "sub", "mul".
- LATENCY, 2: execute cycles (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cl_valid  in  NUM_CLIENTS  client i has an operand pair pending.
- cl_req  out  NUM_CLIENTS  operand pull request to client i.
- cl_ack  in  NUM_CLIENTS  client i presents operands (one-cycle pulse).
- cl_din  in  NUM_CLIENTS*2*DATA_WIDTH  per-client slice i: a = low DATA_WIDTH bits, b = high DATA_WIDTH bits.
- res_req  in  NUM_CLIENTS  client i result sink ready.
- res_ack  out  NUM_CLIENTS  one-cycle result strobe to client i.
- res_dout  out  DATA_WIDTH  shared result bus.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_CLIENTS)  index of the current or last granted client.
- stat_count  out  NUM_CLIENTS*32  per-client completion counters (see Optional Feature).

Behaviour:
- Reset (rst=0, async) drives:
  - cl_req=0, res_ack=0, res_dout=0, busy=0, grant_id=0, stat_count=0.
  - State IDLE, rotation pointer ptr=0, latency counter=0.
  - Any in-flight transaction is discarded.
- State machine, all outputs registered:
  - IDLE: if any cl_valid, select g = the first index >= ptr with cl_valid[g]=1, wrapping modulo NUM_CLIENTS. Set grant_id<=g and cl_req[g]<=1, go to GRANT. Otherwise stay in IDLE.
  - GRANT: cl_req[g] held high until cl_ack[g]=1 is sampled. On that edge:
    - latch a, b from slice g;
    - cl_req[g]<=0;
    - load cnt<=LATENCY-1;
    - go to EXEC.
  - cl_valid[g] falling during GRANT does not abort; the grant persists until the ack.
  - EXEC: when cnt==0, res_dout<=a OP b and go to DELIVER. Otherwise cnt<=cnt-1.
  - DELIVER: when res_req[g]=1, res_ack[g]<=1 for exactly one cycle, ptr<=(g+1) mod NUM_CLIENTS, go to IDLE.
- Latency:
  - cl_ack sampled at edge T, LATENCY=L: res_dout updates at edge T+L.
  - If res_req[g] is already high, res_ack rises at T+L+1.
  - cl_req rises one cycle after cl_valid is seen in IDLE.
- Arithmetic: a+b, a-b (a minus b) or a*b, truncated to DATA_WIDTH, wrap-around, unsigned.
- res_dout holds its value until the next result; it is never cleared except by reset.
- At most one cl_req bit and at most one res_ack bit are high at any time.
- cl_ack and res_req on non-granted indices are ignored.
- cl_ack while not in GRANT is ignored.
- Back-to-back: the next grant starts in the cycle after DELIVER completes, so the minimum per-transaction period is LATENCY+3 cycles.
- All clients valid: grants rotate 0,1,2,...,N-1,0. No starvation; each client waits at most NUM_CLIENTS-1 transactions.
- Single requester: the same client is re-granted every transaction.

Optional Feature:
- Macro: SHARED_FU_ARBITER_STATS_EN.
- Defined: stat_count slice i (32 bits) increments on each res_ack[i] pulse. It wraps at 2^32 and is cleared only by reset.
- Undefined: stat_count is tied to 0, no counter flops are built, and all other behaviour is identical.

Test Plan:
- Reset mid-EXEC:
  - stimulus: client 1 granted with a=5, b=7, rst pulled low during EXEC;
  - required: all outputs 0 immediately (asynchronously), no res_ack afterwards, next grant goes to the lowest valid index starting at 0.
- Single add, NUM_CLIENTS=4, LATENCY=2, OP=add:
  - stimulus: client 2 valid, a=3, b=4, res_req high;
  - required: res_dout=7 exactly 2 cycles after the ack edge, res_ack[2] pulse one cycle later, grant_id=2.
- Round-robin:
  - stimulus: all four clients valid continuously, each with a=i, b=10;
  - required: results in order 10,11,12,13,10, with res_ack order 0,1,2,3,0.
- Backpressure:
  - stimulus: res_req[0]=0 for 20 cycles after the result;
  - required: state stays DELIVER, busy=1, no cl_req to other clients; res_ack[0] fires one cycle after res_req[0] rises.
- Wrap and sub:
  - stimulus: OP=sub, a=0, b=1;
  - required: res_dout=32'hFFFFFFFF.
  - stimulus: OP=mul, a=32'h10000, b=32'h10000;
  - required: res_dout=0.
- Stats (macro defined):
  - stimulus: 3 transactions for client 1, 1 for client 3;
  - required: stat_count slices = {0,3,0,1}. With the macro undefined, all slices are 0.

Source files
------------

// File: rtl/shared_fu_arbiter.sv
// shared_fu_arbiter: folds one arithmetic unit (add/sub/mul) onto NUM_CLIENTS
// req/ack dataflow channels, serving one transaction at a time in round-robin order.
// Optional build macro: SHARED_FU_ARBITER_STATS_EN enables per-client completion counters.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   cl_valid      client i has an operand pair pending
//   cl_req        operand pull request to client i (one-hot or zero)
//   cl_ack        client i presents operands on cl_din (one-cycle pulse)
//   cl_din        per-client slice i: a = low DATA_WIDTH bits, b = high DATA_WIDTH bits
//   res_req       client i result sink ready
//   res_ack       one-cycle result strobe to client i
//   res_dout      shared result bus, holds until the next result
//   busy          high whenever the arbiter is not idle
//   grant_id      index of the current or last granted client
//   stat_count    32-bit completion counter per client (zero unless stats are built)
module shared_fu_arbiter #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter string       OP          = "add",
    parameter int unsigned LATENCY     = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CLIENTS-1:0]              cl_valid,
    output logic [NUM_CLIENTS-1:0]              cl_req,
    input  logic [NUM_CLIENTS-1:0]              cl_ack,
    input  logic [NUM_CLIENTS*2*DATA_WIDTH-1:0] cl_din,
    input  logic [NUM_CLIENTS-1:0]              res_req,
    output logic [NUM_CLIENTS-1:0]              res_ack,
    output logic [DATA_WIDTH-1:0]               res_dout,
    output logic                                busy,
    output logic [$clog2(NUM_CLIENTS)-1:0]      grant_id,
    output logic [NUM_CLIENTS*32-1:0]           stat_count
);

    localparam int unsigned GID_W = $clog2(NUM_CLIENTS);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_EXEC    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [GID_W-1:0]        ptr_q, ptr_d;
    logic [GID_W-1:0]        gid_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_WIDTH-1:0]   dout_d;
    logic [NUM_CLIENTS-1:0]  req_d, ack_d;
    logic                    busy_d;
    logic [DATA_WIDTH-1:0]   din_a [NUM_CLIENTS];
    logic [DATA_WIDTH-1:0]   din_b [NUM_CLIENTS];
    logic [DATA_WIDTH-1:0]   op_res_c;
    logic [GID_W-1:0]        sel_hi_c, sel_lo_c, sel_c;
    logic                    found_hi_c;

    // Unpack the per-client operand slices.
    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_din
        assign din_a[i] = cl_din[i*2*DATA_WIDTH +: DATA_WIDTH];
        assign din_b[i] = cl_din[i*2*DATA_WIDTH + DATA_WIDTH +: DATA_WIDTH];
    end

    // The shared functional unit; results wrap to DATA_WIDTH.
    if (OP == "sub") begin : g_sub
        assign op_res_c = a_q - b_q;
    end else if (OP == "mul") begin : g_mul
        assign op_res_c = a_q * b_q;
    end else begin : g_add
        assign op_res_c = a_q + b_q;
    end

    // Round-robin pick: lowest valid index >= ptr, else lowest valid index overall.
    always_comb begin
        found_hi_c = 1'b0;
        sel_hi_c   = '0;
        sel_lo_c   = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (cl_valid[i]) begin
                sel_lo_c = GID_W'(i);
                if (GID_W'(i) >= ptr_q) begin
                    sel_hi_c   = GID_W'(i);
                    found_hi_c = 1'b1;
                end
            end
        end
        sel_c = found_hi_c ? sel_hi_c : sel_lo_c;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = grant_id;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        dout_d  = res_dout;
        req_d   = cl_req;
        ack_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (|cl_valid) begin
                    gid_d        = sel_c;
                    req_d        = '0;
                    req_d[sel_c] = 1'b1;
                    state_d      = S_GRANT;
                end
            end
            S_GRANT: begin
                if (cl_ack[grant_id]) begin
                    a_d     = din_a[grant_id];
                    b_d     = din_b[grant_id];
                    req_d   = '0;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    dout_d  = op_res_c;
                    state_d = S_DELIVER;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DELIVER: begin
                if (res_req[grant_id]) begin
                    ack_d[grant_id] = 1'b1;
                    ptr_d   = (grant_id == GID_W'(NUM_CLIENTS - 1)) ? '0 : grant_id + GID_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            grant_id <= '0;
            cl_req   <= '0;
            res_ack  <= '0;
            res_dout <= '0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            grant_id <= gid_d;
            cl_req   <= req_d;
            res_ack  <= ack_d;
            res_dout <= dout_d;
            busy     <= busy_d;
        end
    end

`ifdef SHARED_FU_ARBITER_STATS_EN
    // Completion counters advance on the same edge that raises res_ack[i].
    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_stat
        logic [31:0] cnt;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= '0;
            end else if (ack_d[i]) begin
                cnt <= cnt + 32'd1;
            end
        end
        assign stat_count[i*32 +: 32] = cnt;
    end
`else
    assign stat_count = '0;
`endif

endmodule

// File: tb/tb_shared_fu_arbiter.sv
`timescale 1ns/1ps
// Bench for shared_fu_arbiter: a transaction-level reference model checked every
// cycle against the main (add, 4 clients, latency 2) instance, plus directed
// literal checks on it and on small sub and mul instances.
module tb_shared_fu_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 2;
    localparam int unsigned GW  = 2;

    logic              clk;
    logic              rst;
    logic [N-1:0]      cl_valid, cl_req, cl_ack, res_req, res_ack, junk_ack;
    logic [N*2*DW-1:0] cl_din;
    logic [DW-1:0]     res_dout;
    logic              busy;
    logic [GW-1:0]     grant_id;
    logic [N*32-1:0]   stat_count;
    logic [DW-1:0]     op_a [N];
    logic [DW-1:0]     op_b [N];

    // sub instance (2 clients, latency 1) and mul instance (2 clients, latency 3)
    logic [1:0]   su_valid, su_req, su_rack;
    logic [127:0] su_din;
    logic [DW-1:0] su_dout;
    logic         su_busy;
    logic [0:0]   su_gid;
    logic [63:0]  su_stat;
    logic [1:0]   mu_valid, mu_req, mu_rack;
    logic [127:0] mu_din;
    logic [DW-1:0] mu_dout;
    logic         mu_busy;
    logic [0:0]   mu_gid;
    logic [63:0]  mu_stat;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clients acknowledge as soon as they see their request; junk_ack injects stray acks.
    assign cl_ack = cl_req | junk_ack;
    for (genvar i = 0; i < N; i++) begin : g_din
        assign cl_din[i*2*DW +: DW]      = op_a[i];
        assign cl_din[i*2*DW + DW +: DW] = op_b[i];
    end

    shared_fu_arbiter #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .OP("add"), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .cl_valid(cl_valid), .cl_req(cl_req), .cl_ack(cl_ack),
        .cl_din(cl_din), .res_req(res_req), .res_ack(res_ack), .res_dout(res_dout),
        .busy(busy), .grant_id(grant_id), .stat_count(stat_count));

    shared_fu_arbiter #(.NUM_CLIENTS(2), .DATA_WIDTH(DW), .OP("sub"), .LATENCY(1)) u_sub (
        .clk(clk), .rst(rst), .cl_valid(su_valid), .cl_req(su_req), .cl_ack(su_req),
        .cl_din(su_din), .res_req(2'b11), .res_ack(su_rack), .res_dout(su_dout),
        .busy(su_busy), .grant_id(su_gid), .stat_count(su_stat));

    shared_fu_arbiter #(.NUM_CLIENTS(2), .DATA_WIDTH(DW), .OP("mul"), .LATENCY(3)) u_mul (
        .clk(clk), .rst(rst), .cl_valid(mu_valid), .cl_req(mu_req), .cl_ack(mu_req),
        .cl_din(mu_din), .res_req(2'b11), .res_ack(mu_rack), .res_dout(mu_dout),
        .busy(mu_busy), .grant_id(mu_gid), .stat_count(mu_stat));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit            m_active, m_acked;
    int            m_ack_edge, e;
    logic [GW-1:0] m_g, m_ptr;
    logic [DW-1:0] m_a, m_b, m_dout;
    logic [N-1:0]  m_req, m_rack;
    logic [31:0]   m_stat [N];

    function automatic logic [GW-1:0] rr_pick(input logic [GW-1:0] p, input logic [N-1:0] v);
        logic [GW-1:0] idx;
        for (int k = 0; k < N; k++) begin
            idx = GW'((int'(p) + k) % N);
            if (v[idx]) return idx;
        end
        return '0;
    endfunction

    function automatic logic [N*32-1:0] m_stat_vec();
        logic [N*32-1:0] v;
        v = '0;
`ifdef SHARED_FU_ARBITER_STATS_EN
        for (int i = 0; i < N; i++) v[i*32 +: 32] = m_stat[i];
`endif
        return v;
    endfunction

    task automatic model_reset();
        m_active = 0; m_acked = 0; m_ack_edge = 0; e = 0;
        m_g = '0; m_ptr = '0; m_a = '0; m_b = '0; m_dout = '0;
        m_req = '0; m_rack = '0;
        for (int i = 0; i < N; i++) m_stat[i] = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_reset();
            end else begin
                e++;
                m_rack = '0;
                if (!m_active) begin
                    if (cl_valid != '0) begin
                        m_g = rr_pick(m_ptr, cl_valid);
                        m_active = 1; m_acked = 0;
                    end
                end else if (!m_acked) begin
                    if (cl_ack[m_g]) begin
                        m_acked = 1; m_ack_edge = e;
                        m_a = op_a[m_g]; m_b = op_b[m_g];
                    end
                end else if (e == m_ack_edge + int'(LAT)) begin
                    m_dout = m_a + m_b;
                end else if (e > m_ack_edge + int'(LAT) && res_req[m_g]) begin
                    m_rack[m_g] = 1'b1;
                    m_stat[m_g] = m_stat[m_g] + 32'd1;
                    m_ptr = GW'((int'(m_g) + 1) % N);
                    m_active = 0;
                end
                m_req = '0;
                if (m_active && !m_acked) m_req[m_g] = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                check("cyc_cl_req",   128'(cl_req),     128'(m_req));
                check("cyc_res_ack",  128'(res_ack),    128'(m_rack));
                check("cyc_res_dout", 128'(res_dout),   128'(m_dout));
                check("cyc_busy",     128'(busy),       128'(m_active));
                check("cyc_grant_id", 128'(grant_id),   128'(m_g));
                check("cyc_stat",     128'(stat_count), 128'(m_stat_vec()));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_rack(input logic [N-1:0] mask, input string name, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while ((res_ack & mask) == '0 && n < 200);
        check({name, "_timeout"}, 128'(n < 200), 128'(1));
    endtask

    task automatic wait_req(input logic [N-1:0] mask, input string name, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while ((cl_req & mask) == '0 && n < 200);
        check({name, "_timeout"}, 128'(n < 200), 128'(1));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_cl_req"},   128'(cl_req),     128'(0));
        check({name, "_res_ack"},  128'(res_ack),    128'(0));
        check({name, "_res_dout"}, 128'(res_dout),   128'(0));
        check({name, "_busy"},     128'(busy),       128'(0));
        check({name, "_grant_id"}, 128'(grant_id),   128'(0));
        check({name, "_stat"},     128'(stat_count), 128'(0));
    endtask

    int n, c, c_dout;
    int rr_id [5]  = '{0, 1, 2, 3, 0};
    int rr_res [5] = '{10, 11, 12, 13, 10};
    logic [127:0] exp_stat;

    initial begin
        rst = 1'b0; cl_valid = '0; res_req = '0; junk_ack = '0;
        su_valid = '0; su_din = '0; mu_valid = '0; mu_din = '0;
        for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_su_dout", 128'(su_dout), 128'(0));
        rst = 1'b1;

        // sub: 0 - 1 wraps to all ones, latency 1
        su_din[63:0] = {32'd1, 32'd0};
        su_valid = 2'b01;
        n = 0;
        do begin @(negedge clk); n++; end while (su_rack == 2'b00 && n < 50);
        check("sub_timeout", 128'(n < 50), 128'(1));
        check("sub_latency", 128'(n), 128'(4));
        check("sub_ack",     128'(su_rack), 128'(2'b01));
        check("sub_result",  128'(su_dout), 128'(32'hFFFF_FFFF));
        check("sub_gid",     128'(su_gid), 128'(0));
        su_valid = '0;
        @(negedge clk);
        check("sub_ack_pulse", 128'(su_rack), 128'(0));
        check("sub_idle",      128'(su_busy), 128'(0));

        // mul: 3*5 then 0x10000*0x10000 wraps to 0, latency 3
        mu_din[63:0]   = {32'd5, 32'd3};
        mu_din[127:64] = {32'h0001_0000, 32'h0001_0000};
        mu_valid = 2'b01;
        n = 0;
        do begin @(negedge clk); n++; end while (mu_rack == 2'b00 && n < 50);
        check("mul0_latency", 128'(n), 128'(6));
        check("mul0_ack",     128'(mu_rack), 128'(2'b01));
        check("mul0_result",  128'(mu_dout), 128'(15));
        mu_valid = 2'b10;
        n = 0;
        do begin @(negedge clk); n++; end while (mu_rack == 2'b00 && n < 50);
        check("mul1_latency", 128'(n), 128'(6));
        check("mul1_ack",     128'(mu_rack), 128'(2'b10));
        check("mul1_result",  128'(mu_dout), 128'(0));
        check("mul1_gid",     128'(mu_gid), 128'(1));
        mu_valid = '0;
        @(negedge clk);
        check("mul_idle", 128'(mu_busy), 128'(0));
`ifdef SHARED_FU_ARBITER_STATS_EN
        check("sub_stat", 128'(su_stat), 128'(64'h0000_0000_0000_0001));
        check("mul_stat", 128'(mu_stat), 128'(64'h0000_0001_0000_0001));
`else
        check("sub_stat", 128'(su_stat), 128'(0));
        check("mul_stat", 128'(mu_stat), 128'(0));
`endif

        // reset in the middle of execution on client 1
        op_a[1] = 32'd5; op_b[1] = 32'd7;
        res_req = '1;
        cl_valid = 4'b0010;
        wait_req(4'b0010, "rm_req", n);
        check("rm_gid", 128'(grant_id), 128'(1));
        @(negedge clk);
        check("rm_exec_busy", 128'(busy), 128'(1));
        check("rm_exec_req",  128'(cl_req), 128'(0));
        #2 rst = 1'b0;
        #1 check_all_zero("rm_async");
        cl_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("rm_no_ack",  128'(res_ack), 128'(0));
            check("rm_no_busy", 128'(busy), 128'(0));
        end

        // round robin with all clients valid: a=i, b=10
        for (int i = 0; i < N; i++) begin op_a[i] = DW'(i); op_b[i] = 32'd10; end
        cl_valid = '1;
        for (int t = 0; t < 5; t++) begin
            wait_rack('1, "rr", n);
            check("rr_ack_order", 128'(res_ack), 128'(4'(1) << rr_id[t]));
            check("rr_result",    128'(res_dout), 128'(rr_res[t]));
        end

        // single add on client 2
        cl_valid = 4'b0100;
        op_a[2] = 32'd3; op_b[2] = 32'd4;
        wait_req(4'b0100, "add_req", n);
        check("add_gid_req", 128'(grant_id), 128'(2));
        c = 0; c_dout = -1;
        do begin
            @(negedge clk); c++;
            if (c_dout < 0 && res_dout == 32'd7) c_dout = c;
        end while (res_ack[2] == 1'b0 && c < 50);
        check("add_timeout",  128'(c < 50), 128'(1));
        check("add_result",   128'(res_dout), 128'(7));
        check("add_dout_lat", 128'(c_dout), 128'(3));
        check("add_ack_lat",  128'(c), 128'(4));
        check("add_ack",      128'(res_ack), 128'(4'b0100));
        check("add_gid",      128'(grant_id), 128'(2));

        // backpressure on client 0 with client 1 also waiting
        cl_valid = 4'b0011;
        res_req  = 4'b1110;
        op_a[0] = 32'd1; op_b[0] = 32'd2;
        n = 0;
        do begin @(negedge clk); n++; end while (res_dout != 32'd3 && n < 50);
        check("bp_timeout", 128'(n < 50), 128'(1));
        junk_ack = '1;
        repeat (20) begin
            @(negedge clk);
            check("bp_busy",    128'(busy), 128'(1));
            check("bp_no_req",  128'(cl_req), 128'(0));
            check("bp_no_ack",  128'(res_ack), 128'(0));
            check("bp_gid",     128'(grant_id), 128'(0));
        end
        junk_ack = '0;
        res_req  = '1;
        @(negedge clk);
        check("bp_ack",    128'(res_ack), 128'(4'b0001));
        check("bp_result", 128'(res_dout), 128'(3));

        // statistics: three transactions for client 1, one for client 3
        cl_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("st_reset", 128'(stat_count), 128'(0));
        op_a[1] = 32'd5; op_b[1] = 32'd7;
        cl_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            wait_rack(4'b0010, "st_c1", n);
            check("st_c1_gid",    128'(grant_id), 128'(1));
            check("st_c1_result", 128'(res_dout), 128'(12));
        end
        op_a[3] = 32'd100; op_b[3] = 32'd1;
        cl_valid = 4'b1000;
        wait_rack(4'b1000, "st_c3", n);
        check("st_c3_result", 128'(res_dout), 128'(101));
        cl_valid = '0;
        @(negedge clk);
`ifdef SHARED_FU_ARBITER_STATS_EN
        exp_stat = 128'h0000_0001_0000_0000_0000_0003_0000_0000;
`else
        exp_stat = '0;
`endif
        check("st_final", 128'(stat_count), exp_stat);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
